// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one byte-level I2C master between NUM_REQ requesters.
// The owner keeps the bus for a whole transaction. Its command stream is muxed
// into the master and master responses are routed back to it. An inactivity
// timeout aborts a stuck transaction, and a bus-free gap separates owners.
// Optional build macro: I2C_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins). The default build uses round-robin arbitration.
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int CMD_W          = 16,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int GAP_CYCLES     = 130
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  output logic [NUM_REQ-1:0]       o_gnt,
  input  logic [NUM_REQ-1:0]       i_cmd_valid,
  input  logic [NUM_REQ*CMD_W-1:0] i_cmd,
  output logic [NUM_REQ-1:0]       o_cmd_ready,
  output logic                     o_m_cmd_valid,
  output logic [CMD_W-1:0]         o_m_cmd,
  input  logic                     i_m_cmd_ready,
  input  logic                     i_m_rsp_valid,
  input  logic [7:0]               i_m_rsp_data,
  input  logic                     i_m_rsp_err,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  output logic [7:0]               o_rsp_data,
  output logic                     o_rsp_err,
  output logic                     o_m_abort,
  output logic                     o_timeout,
  output logic                     o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [IDX_W-1:0]   winner;
  logic               owned;
  logic               room;
  logic               accept;
  logic               rsp_hit;
  logic               abort;

  // Choose the requester that wins the bus if the arbiter is idle this cycle.
  always_comb begin
    winner = '0;
`ifdef I2C_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) winner = IDX_W'(k);
    end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req[(int'(last_q) + k) % NUM_REQ]) winner = IDX_W'((int'(last_q) + k) % NUM_REQ);
    end
`endif
  end

  // Owner datapath: command mux, ready fan-out, response routing and abort detect.
  always_comb begin
    owned         = (state_q == BUSY) || (state_q == DRAIN);
    room          = (out_q < OUT_MAX);
    o_m_cmd_valid = (state_q == BUSY) && i_cmd_valid[own_q] && room;
    o_m_cmd       = (state_q == BUSY) ? i_cmd[int'(own_q)*CMD_W +: CMD_W] : '0;
    o_cmd_ready   = '0;
    if ((state_q == BUSY) && i_m_cmd_ready && room) o_cmd_ready[own_q] = 1'b1;
    accept        = o_m_cmd_valid && i_m_cmd_ready;
    rsp_hit       = owned && i_m_rsp_valid && (out_q != '0);
    o_rsp_valid   = '0;
    if (rsp_hit) o_rsp_valid[own_q] = 1'b1;
    o_rsp_data    = owned ? i_m_rsp_data : '0;
    o_rsp_err     = owned && i_m_rsp_err;
    abort         = owned && (tmo_q == TMO_LAST) && !accept && !rsp_hit;
    o_m_abort     = abort;
    o_timeout     = abort;
    o_busy        = (state_q != IDLE);
    o_gnt         = gnt_q;
  end

  // Next-state logic for the arbitration FSM and its counters.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    last_d  = last_q;
    out_d   = out_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = BUSY;
          own_d   = winner;
          last_d  = winner;
          gnt_d   = NUM_REQ'(1) << winner;
          out_d   = '0;
          tmo_d   = '0;
        end
      end
      BUSY, DRAIN: begin
        if (abort) begin
          state_d = RELEASE;
          gnt_d   = '0;
          out_d   = '0;
          tmo_d   = '0;
          gap_d   = '0;
        end else begin
          if (accept && !rsp_hit) out_d = out_q + 1'b1;
          else if (!accept && rsp_hit) out_d = out_q - 1'b1;
          tmo_d = (accept || rsp_hit) ? '0 : tmo_q + 1'b1;
          if ((state_q == BUSY) && !i_req[own_q]) state_d = DRAIN;
          if ((state_q == DRAIN) && (out_q == '0)) begin
            state_d = RELEASE;
            gnt_d   = '0;
            tmo_d   = '0;
            gap_d   = '0;
          end
        end
      end
      RELEASE: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; requester 0 gets first pick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      out_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level
// model of the arbiter (owner, outstanding count, idle run, gap countdown).
module tb_i2c_bus_arbiter;

  localparam int NR = 2;
  localparam int CW = 16;
  localparam int MO = 4;
  localparam int TO = 100;
  localparam int GP = 130;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [NR-1:0]    i_req = '0;
  logic [NR-1:0]    o_gnt;
  logic [NR-1:0]    i_cmd_valid = '0;
  logic [NR*CW-1:0] i_cmd = '0;
  logic [NR-1:0]    o_cmd_ready;
  logic             o_m_cmd_valid;
  logic [CW-1:0]    o_m_cmd;
  logic             i_m_cmd_ready = 1'b0;
  logic             i_m_rsp_valid = 1'b0;
  logic [7:0]       i_m_rsp_data = '0;
  logic             i_m_rsp_err = 1'b0;
  logic [NR-1:0]    o_rsp_valid;
  logic [7:0]       o_rsp_data;
  logic             o_rsp_err;
  logic             o_m_abort;
  logic             o_timeout;
  logic             o_busy;

  int checks = 0;
  int errors = 0;

  // Free-running 100 MHz-style clock.
  always #5 i_clk = ~i_clk;

  i2c_bus_arbiter #(
    .NUM_REQ(NR), .CMD_W(CW), .MAX_OUT(MO), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_gnt(o_gnt),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
    .o_m_cmd_valid(o_m_cmd_valid), .o_m_cmd(o_m_cmd), .i_m_cmd_ready(i_m_cmd_ready),
    .i_m_rsp_valid(i_m_rsp_valid), .i_m_rsp_data(i_m_rsp_data), .i_m_rsp_err(i_m_rsp_err),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_m_abort(o_m_abort), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  // One comparison: count it, and report it if the DUT disagrees.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Drive every DUT input at once.
  task automatic applyStimulus(input logic rstN, input logic [NR-1:0] req, input logic [NR-1:0] cmdValid,
                               input logic [NR*CW-1:0] cmd, input logic mReady, input logic rspValid,
                               input logic [7:0] rspData, input logic rspErr);
    i_rst_n       = rstN;
    i_req         = req;
    i_cmd_valid   = cmdValid;
    i_cmd         = cmd;
    i_m_cmd_ready = mReady;
    i_m_rsp_valid = rspValid;
    i_m_rsp_data  = rspData;
    i_m_rsp_err   = rspErr;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Model state: owner index (-1 = nobody), outstanding commands, inactivity
  // run, remaining bus-free gap cycles, round-robin pointer, draining flag.
  int mOwner, mOut, mIdle, mGapLeft, mLast;
  bit mDraining;
  bit eAccept, eRspHit, eAbort;

  function automatic int pickWinner(input logic [NR-1:0] req, input int last);
`ifdef I2C_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (req[k]) return k;
`else
    for (int k = 1; k <= NR; k++) if (req[(last + k) % NR]) return (last + k) % NR;
`endif
    return -1;
  endfunction

  task automatic modelRelease();
    mOwner    = -1;
    mOut      = 0;
    mIdle     = 0;
    mGapLeft  = GP;
    mDraining = 0;
  endtask

  task automatic modelReset();
    mOwner    = -1;
    mOut      = 0;
    mIdle     = 0;
    mGapLeft  = 0;
    mLast     = NR - 1;
    mDraining = 0;
  endtask

  // Compare process: on each falling edge predict every output from the model
  // and the current inputs, then advance the model at the rising edge.
  initial begin : compareProc
    logic [NR-1:0] expGnt, expReady, expRsp;
    logic [CW-1:0] expCmd;
    bit granted, active, room, expMValid;
    int outBefore, w;
    @(posedge i_clk);
    modelReset();
    forever begin
      @(negedge i_clk);
      granted   = (mOwner >= 0);
      active    = granted && !mDraining;
      room      = (mOut < MO);
      expGnt    = granted ? NR'(1) << mOwner : '0;
      expMValid = active && i_cmd_valid[mOwner] && room;
      expCmd    = active ? i_cmd[mOwner*CW +: CW] : '0;
      expReady  = (active && i_m_cmd_ready && room) ? NR'(1) << mOwner : '0;
      eAccept   = expMValid && i_m_cmd_ready;
      eRspHit   = granted && i_m_rsp_valid && (mOut > 0);
      expRsp    = eRspHit ? NR'(1) << mOwner : '0;
      eAbort    = granted && (mIdle == TO - 1) && !eAccept && !eRspHit;
      checkOutput("gnt", o_gnt, expGnt);
      checkOutput("cmd_ready", o_cmd_ready, expReady);
      checkOutput("m_cmd_valid", o_m_cmd_valid, expMValid);
      checkOutput("m_cmd", o_m_cmd, expCmd);
      checkOutput("rsp_valid", o_rsp_valid, expRsp);
      checkOutput("rsp_data", o_rsp_data, granted ? i_m_rsp_data : 8'h00);
      checkOutput("rsp_err", o_rsp_err, granted && i_m_rsp_err);
      checkOutput("m_abort", o_m_abort, eAbort);
      checkOutput("timeout", o_timeout, eAbort);
      checkOutput("busy", o_busy, granted || (mGapLeft > 0));
      @(posedge i_clk);
      if (!i_rst_n) begin
        modelReset();
      end else if (mOwner >= 0) begin
        if (eAbort) begin
          modelRelease();
        end else begin
          outBefore = mOut;
          mOut  = mOut + (eAccept ? 1 : 0) - (eRspHit ? 1 : 0);
          mIdle = (eAccept || eRspHit) ? 0 : mIdle + 1;
          if (mDraining) begin
            if (outBefore == 0) modelRelease();
          end else if (!i_req[mOwner]) begin
            mDraining = 1;
          end
        end
      end else if (mGapLeft > 0) begin
        mGapLeft--;
      end else begin
        w = pickWinner(i_req, mLast);
        if (w >= 0) begin
          mOwner    = w;
          mLast     = w;
          mOut      = 0;
          mIdle     = 0;
          mDraining = 0;
        end
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin : stimulusProc
    int n, acc, strobes;
    logic [NR-1:0] rrExp [2];
    logic [NR-1:0] r;
`ifdef I2C_ARB_FIXED_PRIO_EN
    rrExp[0] = 2'b01; rrExp[1] = 2'b01;
`else
    rrExp[0] = 2'b10; rrExp[1] = 2'b01;
`endif
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst_gnt", o_gnt, 2'b00);
    checkOutput("rst_busy", o_busy, 1'b0);

    // Single requester: three commands, each answered two cycles later.
    i_rst_n = 1'b1;
    i_req   = 2'b01;
    tick();
    checkOutput("t1_gnt", o_gnt, 2'b01);
    for (int c = 0; c < 3; c++) begin
      i_cmd[CW-1:0] = CW'(16'hA000 + c);
      i_cmd_valid   = 2'b01;
      i_m_cmd_ready = 1'b1;
      #1;
      checkOutput("t1_mcmd", o_m_cmd, 32'hA000 + c);
      tick();
      i_cmd_valid = 2'b00;
      tick();
      i_m_rsp_valid = 1'b1;
      i_m_rsp_data  = 8'(8'h30 + c);
      #1;
      checkOutput("t1_rsp_valid", o_rsp_valid, 2'b01);
      checkOutput("t1_rsp_data", o_rsp_data, 32'h30 + c);
      tick();
      i_m_rsp_valid = 1'b0;
    end
    i_req = 2'b00;
    tick();
    checkOutput("t1_drain_gnt", o_gnt, 2'b01);
    tick();
    checkOutput("t1_release_gnt", o_gnt, 2'b00);
    checkOutput("t1_release_busy", o_busy, 1'b1);
    n = 0;
    while (o_busy && n < 1000) begin tick(); n++; end
    checkOutput("t1_release_len", n, 130);

    // Round-robin under a held 11 request; each transaction ends by timeout.
    i_rst_n = 1'b0;
    i_req   = 2'b11;
    tick();
    i_rst_n = 1'b1;
    tick();
    checkOutput("t2_gnt0", o_gnt, 2'b01);
    for (int t = 0; t < 2; t++) begin
      n = 0;
      while (!o_m_abort && n < 1000) begin tick(); n++; end
      checkOutput("t2_abort_at", n, 99);
      checkOutput("t2_timeout", o_timeout, 1'b1);
      tick();
      checkOutput("t2_gnt_after_abort", o_gnt, 2'b00);
      checkOutput("t2_abort_pulse", o_m_abort, 1'b0);
      n = 0;
      while (o_gnt == '0 && n < 1000) begin tick(); n++; end
      checkOutput("t2_regrant_wait", n, 131);
      checkOutput("t2_gnt_next", o_gnt, rrExp[t]);
    end

    // Backpressure: six commands offered, master withholds responses.
    i_rst_n = 1'b0;
    i_req   = 2'b00;
    tick();
    i_rst_n = 1'b1;
    i_req   = 2'b01;
    tick();
    i_cmd_valid   = 2'b01;
    i_m_cmd_ready = 1'b1;
    #1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_cmd_ready[0]) acc++;
      tick();
    end
    checkOutput("t3_accepted", acc, 4);
    checkOutput("t3_ready_full", o_cmd_ready, 2'b00);
    i_m_rsp_valid = 1'b1;
    #1;
    checkOutput("t3_rsp", o_rsp_valid, 2'b01);
    tick();
    i_m_rsp_valid = 1'b0;
    #1;
    checkOutput("t3_ready_again", o_cmd_ready, 2'b01);
    tick();
    checkOutput("t3_ready_full2", o_cmd_ready, 2'b00);

    // Simultaneous accept and response at count 2, then responses at count 0.
    i_cmd_valid   = 2'b00;
    i_m_rsp_valid = 1'b1;
    tick();
    tick();
    i_cmd_valid = 2'b01;
    #1;
    checkOutput("t4_both_ready", o_cmd_ready, 2'b01);
    checkOutput("t4_both_rsp", o_rsp_valid, 2'b01);
    tick();
    i_cmd_valid = 2'b00;
    #1;
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_rsp_valid[0]) strobes++;
      tick();
    end
    checkOutput("t4_count_two", strobes, 2);
    checkOutput("t4_rsp_zero", o_rsp_valid, 2'b00);

    // Reset while BUSY with three commands outstanding.
    i_m_rsp_valid = 1'b0;
    i_cmd_valid   = 2'b01;
    tick();
    tick();
    tick();
    i_rst_n       = 1'b0;
    i_m_rsp_valid = 1'b1;
    i_m_rsp_data  = 8'hFF;
    i_m_rsp_err   = 1'b1;
    tick();
    checkOutput("t5_gnt", o_gnt, 2'b00);
    checkOutput("t5_ready", o_cmd_ready, 2'b00);
    checkOutput("t5_mvalid", o_m_cmd_valid, 1'b0);
    checkOutput("t5_mcmd", o_m_cmd, 32'h0);
    checkOutput("t5_rsp", o_rsp_valid, 2'b00);
    checkOutput("t5_rsp_data", o_rsp_data, 32'h0);
    checkOutput("t5_rsp_err", o_rsp_err, 1'b0);
    checkOutput("t5_abort", o_m_abort, 1'b0);
    checkOutput("t5_busy", o_busy, 1'b0);
    i_rst_n       = 1'b1;
    i_req         = 2'b11;
    i_cmd_valid   = 2'b00;
    i_m_rsp_valid = 1'b0;
    i_m_rsp_err   = 1'b0;
    tick();
    checkOutput("t5_gnt_after", o_gnt, 2'b01);

    // Randomized traffic; the compare process checks every cycle.
    r = i_req;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      for (int k = 0; k < NR; k++) if ($urandom_range(0, 49) == 0) r[k] = ~r[k];
      applyStimulus($urandom_range(0, 2999) != 0, r, NR'($urandom), (NR*CW)'({$urandom, $urandom}),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
